// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types and helpers for the uart_tx scheduler.
//   state_t       scheduler FSM encoding
//   DEF_*         default parameter values
//   rr_result_t   result of the round-robin search (found flag + index)
//   rr_next()     wrap-around first-set search starting after 'last'
package uart_sched_pkg;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_LOCK_TIMEOUT = 65535;
    localparam int MAX_REQ          = 8;
    localparam int MAX_IDW          = 3;
    localparam int CNT_W            = 16;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_result_t;

    // Scan last+1, last+2, ... wrapping at n; the first set bit wins.
    // 'last' itself is visited last, so a lone requester can win again.
    function automatic rr_result_t rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [MAX_IDW-1:0] last,
                                           input int unsigned        n);
        rr_result_t  r;
        logic [3:0]  j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = 4'({1'b0, last}) + 4'(k);
            if (32'(j) >= n) j = j - 4'(n);
            if (k <= n && !r.found && req[j[MAX_IDW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[MAX_IDW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester and uart_tx handshake bundle.
//   req/req_lock/req_data  per-requester byte offer and lock request
//   ack/grant_id/locked    capture pulse and current ownership
//   tx_data/tx_send        registered command to uart_tx
//   tx_ready               uart_tx idle indication
// master: requesters plus uart_tx side; slave: the scheduler.
interface uart_tx_sched_if
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [IDW-1:0]       grant_id;
    logic                 locked;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_ready;

    modport master (
        output req, req_lock, req_data, tx_ready,
        input  ack, grant_id, locked, tx_data, tx_send
    );

    modport slave (
        input  req, req_lock, req_data, tx_ready,
        output ack, grant_id, locked, tx_data, tx_send
    );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   req     request vector
//   last    index granted last time (searched after everything else)
//   winner  chosen index, valid when found=1
//   found   at least one request set
module uart_rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [IDW-1:0]     winner,
    output logic               found
);
    rr_result_t res;

    always_comb begin
        res = rr_next(MAX_REQ'(req), MAX_IDW'(last), NUM_REQ);
    end

    assign winner = IDW'(res.idx);
    assign found  = res.found;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx among NUM_REQ byte producers.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus (slave)   requester handshake and uart_tx command/status
// Round-robin arbitration with an optional per-owner lock so that
// multi-byte messages go out contiguously; an idle lock expires after
// LOCK_TIMEOUT arbitration cycles.
//
// state   | meaning
// S_ARB   | uart_tx idle: pick a byte, capture it, raise tx_send
// S_ISSUE | tx_send held until uart_tx drops tx_ready (send started)
// S_DRAIN | tx_send low, waiting for uart_tx to return to idle
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int IDW          = $clog2(NUM_REQ),
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_sched_if.slave    bus
);
    state_t             state, state_nxt;
    logic [7:0]         tx_data_q, tx_data_nxt;
    logic               tx_send_q, tx_send_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic [IDW-1:0]     grant_q, grant_nxt;
    logic               locked_q, locked_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    logic [IDW-1:0]     pick_win;
    logic               pick_found;
    logic [7:0]         req_byte [NUM_REQ];
    logic               take;
    logic [IDW-1:0]     win;

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req    (bus.req),
        .last   (grant_q),
        .winner (pick_win),
        .found  (pick_found)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = bus.req_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_ARB;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
            ack_q     <= '0;
            grant_q   <= IDW'(NUM_REQ - 1);
            locked_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            tx_data_q <= tx_data_nxt;
            tx_send_q <= tx_send_nxt;
            ack_q     <= ack_nxt;
            grant_q   <= grant_nxt;
            locked_q  <= locked_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_data_nxt = tx_data_q;
        tx_send_nxt = tx_send_q;
        ack_nxt     = '0;
        grant_nxt   = grant_q;
        locked_nxt  = locked_q;
        cnt_nxt     = cnt_q;
        take        = 1'b0;
        win         = pick_win;

        case (state)
            S_ARB: begin
                if (bus.tx_ready) begin
                    if (locked_q) begin
                        // Owner request beats a same-cycle timeout expiry.
                        if (bus.req[grant_q]) begin
                            take = 1'b1;
                            win  = grant_q;
                        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            locked_nxt = 1'b0;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt = cnt_q + 1'b1;
                        end
                    end else if (pick_found) begin
                        take = 1'b1;
                    end
                end
                if (take) begin
                    tx_data_nxt  = req_byte[win];
                    ack_nxt[win] = 1'b1;
                    grant_nxt    = win;
                    locked_nxt   = bus.req_lock[win];
                    cnt_nxt      = '0;
                    tx_send_nxt  = 1'b1;
                    state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.tx_ready) begin
                    tx_send_nxt = 1'b0;
                    state_nxt   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.tx_ready) state_nxt = S_ARB;
            end
            default: state_nxt = S_ARB;
        endcase
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_send  = tx_send_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.locked   = locked_q;
endmodule
